// File: rtl/picorv32_wb_bridge.sv
// PicoRV32 native memory interface to one or two Wishbone classic master ports,
// with optional address-based port split, registered response and bus timeout.
module picorv32_wb_bridge #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    DUAL_PORT      = 0,
    parameter logic [ADDR_WIDTH-1:0] DATA_BASE      = ADDR_WIDTH'(32'h8000_0000),
    parameter logic [ADDR_WIDTH-1:0] DATA_MASK      = ADDR_WIDTH'(32'hF000_0000),
    parameter int                    REGISTER_RESP  = 0,
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(32'hDEAD_BEEF),
    localparam int                   SEL_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                  clk_core,
    input  logic                  rst_core,
    input  logic                  mem_valid,
    input  logic                  mem_instr,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [SEL_WIDTH-1:0]  mem_wstrb,
    output logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  core_cyc,
    output logic                  core_stb,
    output logic                  core_we,
    output logic [SEL_WIDTH-1:0]  core_sel,
    output logic [ADDR_WIDTH-1:0] core_addr,
    output logic [DATA_WIDTH-1:0] core_data_out,
    input  logic [DATA_WIDTH-1:0] core_data_in,
    input  logic                  core_ack,
    output logic                  data_mem_cyc,
    output logic                  data_mem_stb,
    output logic                  data_mem_we,
    output logic [SEL_WIDTH-1:0]  data_mem_sel,
    output logic [ADDR_WIDTH-1:0] data_mem_addr,
    output logic [DATA_WIDTH-1:0] data_mem_data_out,
    input  logic [DATA_WIDTH-1:0] data_mem_data_in,
    input  logic                  data_mem_ack,
    output logic                  bus_error
);

    localparam int             CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam bit             TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam bit             DP_EN    = (DUAL_PORT != 0);
    localparam bit             RR_EN    = (REGISTER_RESP != 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RESP = 3'd2,
        S_ERR  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic                    core_act_q, core_act_d;
    logic                    data_act_q, data_act_d;
    logic                    we_q, we_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    port_q, port_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    hit_s;
    logic                    ack_sel_s;
    logic [DATA_WIDTH-1:0]   din_sel_s;
    logic                    ready_s;
    logic [DATA_WIDTH-1:0]   rdata_s;

    assign hit_s     = DP_EN && !mem_instr && ((mem_addr & DATA_MASK) == DATA_BASE);
    // Only the port that owns the transaction can complete it
    assign ack_sel_s = port_q ? data_mem_ack : core_ack;
    assign din_sel_s = port_q ? data_mem_data_in : core_data_in;

    // Next-state, latched request fields and core-side response
    always_comb begin
        state_d    = state_q;
        core_act_d = core_act_q;
        data_act_d = data_act_q;
        we_d       = we_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        port_d     = port_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        ready_s    = 1'b0;
        rdata_s    = {DATA_WIDTH{1'b0}};
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    state_d    = S_REQ;
                    port_d     = hit_s;
                    core_act_d = !hit_s;
                    data_act_d = hit_s;
                    we_d       = |mem_wstrb;
                    sel_d      = (|mem_wstrb) ? mem_wstrb : {SEL_WIDTH{1'b1}};
                    addr_d     = mem_addr;
                    wdata_d    = mem_wdata;
                    cnt_d      = {CW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                // An ack arriving on the expiry cycle still completes normally
                if (ack_sel_s) begin
                    core_act_d = 1'b0;
                    data_act_d = 1'b0;
                    rdata_d    = din_sel_s;
                    if (RR_EN) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_DONE;
                        ready_s = 1'b1;
                        rdata_s = din_sel_s;
                    end
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    core_act_d = 1'b0;
                    data_act_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = S_ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1'b1);
                end
            end
            S_RESP: begin
                ready_s = 1'b1;
                rdata_s = rdata_q;
                state_d = S_DONE;
            end
            S_ERR: begin
                ready_s = 1'b1;
                rdata_s = ERR_DATA;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                core_act_d = 1'b0;
                data_act_d = 1'b0;
            end
        endcase
    end

    // State and request registers
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state_q    <= S_IDLE;
            core_act_q <= 1'b0;
            data_act_q <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= {SEL_WIDTH{1'b0}};
            addr_q     <= {ADDR_WIDTH{1'b0}};
            wdata_q    <= {DATA_WIDTH{1'b0}};
            port_q     <= 1'b0;
            cnt_q      <= {CW{1'b0}};
            rdata_q    <= {DATA_WIDTH{1'b0}};
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            core_act_q <= core_act_d;
            data_act_q <= data_act_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            port_q     <= port_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign mem_ready         = ready_s;
    assign mem_rdata         = rdata_s;
    assign bus_error         = err_q;

    assign core_cyc          = core_act_q;
    assign core_stb          = core_act_q;
    assign core_we           = we_q;
    assign core_sel          = sel_q;
    assign core_addr         = addr_q;
    assign core_data_out     = wdata_q;

    // The data port stays fully quiet when the split is disabled
    assign data_mem_cyc      = data_act_q;
    assign data_mem_stb      = data_act_q;
    assign data_mem_we       = DP_EN ? we_q : 1'b0;
    assign data_mem_sel      = DP_EN ? sel_q : {SEL_WIDTH{1'b0}};
    assign data_mem_addr     = DP_EN ? addr_q : {ADDR_WIDTH{1'b0}};
    assign data_mem_data_out = DP_EN ? wdata_q : {DATA_WIDTH{1'b0}};

endmodule
